// File: rtl/mem_port_arbiter_if.sv
// Bundles the IFU, LSU and memory handshakes of the shared data-memory port.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface mem_port_arbiter_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_wdata;
    logic [1:0]  lsu_req_size;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [1:0]  mem_req_size;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;

    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_size, lsu_rsp_ready,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_size, mem_rsp_ready,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_size, lsu_rsp_ready,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_size, mem_rsp_ready,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the IFU and LSU: one transaction in flight,
// alignment checking at capture, response routing and a WAIT-state timeout.
module mem_port_arbiter #(
    parameter int LSU_PRIORITY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic              owner,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wen_q, wen_d;
    logic        err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic        mem_rsp_ready_q, mem_rsp_ready_d;
    logic        ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic        lsu_rsp_valid_q, lsu_rsp_valid_d;

    logic        pick_lsu, ifu_gnt, lsu_gnt, illegal, timeout_hit, owner_rsp_ready;
    logic [31:0] cap_addr;
    logic [1:0]  cap_size;
    logic [16:0] cnt_inc;

    // A tie goes to the LSU under fixed priority, else to whoever was not granted last.
    assign pick_lsu = bus.lsu_req_valid &&
                      (!bus.ifu_req_valid || (LSU_PRIORITY != 0) || !last_grant_q);
    assign lsu_gnt  = (state_q == IDLE) && !rst && pick_lsu;
    assign ifu_gnt  = (state_q == IDLE) && !rst && bus.ifu_req_valid && !pick_lsu;

    assign cap_addr = lsu_gnt ? bus.lsu_req_addr : bus.ifu_req_addr;
    assign cap_size = lsu_gnt ? bus.lsu_req_size : 2'd2;
    assign illegal  = (cap_size == 2'd3) ||
                      ((cap_size == 2'd1) && cap_addr[0]) ||
                      ((cap_size == 2'd2) && (cap_addr[1:0] != 2'b00));

    assign cnt_inc         = {1'b0, cnt_q} + 17'd1;
    assign timeout_hit     = (cnt_inc >= TIMEOUT_LIMIT);
    assign owner_rsp_ready = owner_q ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        rdata_d         = rdata_q;
        wen_d           = wen_q;
        err_d           = err_q;
        size_d          = size_q;
        cnt_d           = cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_rsp_ready_d = mem_rsp_ready_q;
        ifu_rsp_valid_d = ifu_rsp_valid_q;
        lsu_rsp_valid_d = lsu_rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (ifu_gnt || lsu_gnt) begin
                    owner_d         = lsu_gnt;
                    last_grant_d    = lsu_gnt;
                    addr_d          = cap_addr;
                    wen_d           = lsu_gnt && bus.lsu_req_wen;
                    wdata_d         = lsu_gnt ? bus.lsu_req_wdata : 32'd0;
                    size_d          = cap_size;
                    cnt_d           = '0;
                    mem_rsp_ready_d = 1'b0;
                    // Illegal accesses answer straight away and never reach memory.
                    if (illegal) begin
                        state_d         = RESP;
                        err_d           = 1'b1;
                        rdata_d         = 32'd0;
                        ifu_rsp_valid_d = ifu_gnt;
                        lsu_rsp_valid_d = lsu_gnt;
                    end else begin
                        state_d         = REQ;
                        mem_req_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.mem_req_ready) begin
                    state_d         = WAIT;
                    mem_req_valid_d = 1'b0;
                    mem_rsp_ready_d = 1'b1;
                    cnt_d           = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc[15:0];
                if (bus.mem_rsp_valid || timeout_hit) begin
                    state_d         = RESP;
                    mem_rsp_ready_d = 1'b0;
                    ifu_rsp_valid_d = !owner_q;
                    lsu_rsp_valid_d = owner_q;
                    if (bus.mem_rsp_valid) begin
                        rdata_d = wen_q ? 32'd0 : bus.mem_rsp_rdata;
                        err_d   = bus.mem_rsp_err;
                    end else begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    state_d         = IDLE;
                    ifu_rsp_valid_d = 1'b0;
                    lsu_rsp_valid_d = 1'b0;
                    mem_rsp_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            last_grant_q    <= 1'b1;
            addr_q          <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            wen_q           <= 1'b0;
            err_q           <= 1'b0;
            size_q          <= '0;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_rsp_ready_q <= 1'b1;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rdata_q         <= rdata_d;
            wen_q           <= wen_d;
            err_q           <= err_d;
            size_q          <= size_d;
            cnt_q           <= cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_rsp_ready_q <= mem_rsp_ready_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
        end
    end

    assign bus.ifu_req_ready = ifu_gnt;
    assign bus.lsu_req_ready = lsu_gnt;
    assign bus.ifu_rsp_valid = ifu_rsp_valid_q;
    assign bus.ifu_rsp_data  = rdata_q;
    assign bus.ifu_rsp_err   = err_q;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
    assign bus.lsu_rsp_rdata = rdata_q;
    assign bus.lsu_rsp_err   = err_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wen   = wen_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_size  = size_q;
    assign bus.mem_rsp_ready = mem_rsp_ready_q;
    assign owner             = owner_q;
    assign busy              = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: dut_p (LSU priority, timeout 4) for directed cases, dut_r
// (round-robin, zero-wait memory) for the alternating tie sequence.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic owner_p, busy_p, owner_r, busy_r;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_cyc;
    bit   found;
    rsp_t mon_e;
    rsp_t exp_p_ifu[$], exp_p_lsu[$], exp_r_ifu[$], exp_r_lsu[$];

    mem_port_arbiter_if bus_p ();
    mem_port_arbiter_if bus_r ();

    mem_port_arbiter #(.LSU_PRIORITY(1), .TIMEOUT_CYCLES(4)) dut_p (
        .clk(clk), .rst(rst), .bus(bus_p), .owner(owner_p), .busy(busy_p));
    mem_port_arbiter #(.LSU_PRIORITY(0), .TIMEOUT_CYCLES(16)) dut_r (
        .clk(clk), .rst(rst), .bus(bus_r), .owner(owner_r), .busy(busy_r));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h9234_5668;
    endfunction

    // Memory models: dut_p's returns mem_word(addr), dut_r's is always ready with ~addr.
    assign bus_p.mem_rsp_rdata = mem_word(bus_p.mem_req_addr);
    assign bus_r.mem_req_ready = 1'b1;
    assign bus_r.mem_rsp_valid = 1'b1;
    assign bus_r.mem_rsp_rdata = ~bus_r.mem_req_addr;
    assign bus_r.mem_rsp_err   = 1'b0;
    assign bus_r.ifu_rsp_ready = 1'b1;
    assign bus_r.lsu_rsp_ready = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit to_lsu, input logic [31:0] addr, input logic wen,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic [31:0] exp_data, input logic exp_err, input bit expect_rsp);
        rsp_t e;
        e.data = exp_data;
        e.err  = exp_err;
        if (to_lsu) begin
            bus_p.lsu_req_addr  = addr;
            bus_p.lsu_req_wen   = wen;
            bus_p.lsu_req_wdata = wdata;
            bus_p.lsu_req_size  = size;
            bus_p.lsu_req_valid = 1'b1;
            if (expect_rsp) exp_p_lsu.push_back(e);
        end else begin
            bus_p.ifu_req_addr  = addr;
            bus_p.ifu_req_valid = 1'b1;
            if (expect_rsp) exp_p_ifu.push_back(e);
        end
    endtask

    task automatic waitGrantAndDrop(input bit to_lsu);
        bit seen = 1'b0;
        for (int w = 0; w < 30 && !seen; w++) begin
            @(negedge clk);
            seen = to_lsu ? bus_p.lsu_req_ready : bus_p.ifu_req_ready;
        end
        checkOutput(to_lsu ? "lsu_grant" : "ifu_grant", 32'(seen), 32'd1);
        @(posedge clk); #1;
        if (to_lsu) bus_p.lsu_req_valid = 1'b0;
        else        bus_p.ifu_req_valid = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        for (int w = 0; w < 60; w++) begin
            if (exp_p_ifu.size() + exp_p_lsu.size() + exp_r_ifu.size() + exp_r_lsu.size() == 0
                && !busy_p && !busy_r) break;
            @(negedge clk);
        end
        checkOutput(tag, 32'(exp_p_ifu.size() + exp_p_lsu.size() + exp_r_ifu.size() + exp_r_lsu.size()), 32'd0);
    endtask

    // Response scoreboard: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_p.lsu_rsp_valid && bus_p.lsu_rsp_ready) begin
                if (exp_p_lsu.size() == 0) checkOutput("p_lsu_unexpected", 32'(bus_p.lsu_rsp_valid), 32'd0);
                else begin
                    mon_e = exp_p_lsu.pop_front();
                    checkOutput("p_lsu_rdata", bus_p.lsu_rsp_rdata, mon_e.data);
                    checkOutput("p_lsu_err", 32'(bus_p.lsu_rsp_err), 32'(mon_e.err));
                end
            end
            if (bus_p.ifu_rsp_valid && bus_p.ifu_rsp_ready) begin
                if (exp_p_ifu.size() == 0) checkOutput("p_ifu_unexpected", 32'(bus_p.ifu_rsp_valid), 32'd0);
                else begin
                    mon_e = exp_p_ifu.pop_front();
                    checkOutput("p_ifu_data", bus_p.ifu_rsp_data, mon_e.data);
                    checkOutput("p_ifu_err", 32'(bus_p.ifu_rsp_err), 32'(mon_e.err));
                end
            end
            if (bus_r.lsu_rsp_valid) begin
                if (exp_r_lsu.size() == 0) checkOutput("r_lsu_unexpected", 32'(bus_r.lsu_rsp_valid), 32'd0);
                else begin
                    mon_e = exp_r_lsu.pop_front();
                    checkOutput("r_lsu_rdata", bus_r.lsu_rsp_rdata, mon_e.data);
                end
            end
            if (bus_r.ifu_rsp_valid) begin
                if (exp_r_ifu.size() == 0) checkOutput("r_ifu_unexpected", 32'(bus_r.ifu_rsp_valid), 32'd0);
                else begin
                    mon_e = exp_r_ifu.pop_front();
                    checkOutput("r_ifu_data", bus_r.ifu_rsp_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus_p.ifu_req_valid = 1'b0; bus_p.ifu_req_addr = '0; bus_p.ifu_rsp_ready = 1'b1;
        bus_p.lsu_req_valid = 1'b0; bus_p.lsu_req_addr = '0; bus_p.lsu_req_wen = 1'b0;
        bus_p.lsu_req_wdata = '0;   bus_p.lsu_req_size = 2'd2; bus_p.lsu_rsp_ready = 1'b1;
        bus_p.mem_req_ready = 1'b1; bus_p.mem_rsp_valid = 1'b1; bus_p.mem_rsp_err = 1'b0;
        bus_r.ifu_req_valid = 1'b0; bus_r.ifu_req_addr = '0;
        bus_r.lsu_req_valid = 1'b0; bus_r.lsu_req_addr = '0; bus_r.lsu_req_wen = 1'b0;
        bus_r.lsu_req_wdata = '0;   bus_r.lsu_req_size = 2'd2;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy_p), 32'd0);
        checkOutput("rst_owner", 32'(owner_p), 32'd0);
        checkOutput("rst_mem_req_valid", 32'(bus_p.mem_req_valid), 32'd0);
        checkOutput("rst_mem_req_addr", bus_p.mem_req_addr, 32'd0);
        checkOutput("rst_rsp_valids", 32'({bus_p.ifu_rsp_valid, bus_p.lsu_rsp_valid}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Zero-wait LSU load: response valid three cycles after the handshake.
        applyStimulus(1'b1, 32'h8000_0010, 1'b0, 32'd0, 2'd2, 32'h1234_5678, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t1_lsu_ready", 32'(bus_p.lsu_req_ready), 32'd1);
        checkOutput("t1_ifu_ready", 32'(bus_p.ifu_req_ready), 32'd0);
        @(posedge clk); #1 bus_p.lsu_req_valid = 1'b0;
        @(negedge clk);
        checkOutput("t1_mem_req_valid", 32'(bus_p.mem_req_valid), 32'd1);
        checkOutput("t1_mem_req_addr", bus_p.mem_req_addr, 32'h8000_0010);
        checkOutput("t1_owner", 32'(owner_p), 32'd1);
        @(negedge clk);
        checkOutput("t1_wait_rsp_ready", 32'(bus_p.mem_rsp_ready), 32'd1);
        @(negedge clk);
        checkOutput("t1_lsu_rsp_c3", 32'(bus_p.lsu_rsp_valid), 32'd1);
        checkOutput("t1_ifu_rsp_c3", 32'(bus_p.ifu_rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1_idle_c4", 32'(busy_p), 32'd0);

        // Tie under LSU priority: LSU first, IFU granted at cycle 4.
        @(posedge clk); #1;
        applyStimulus(1'b0, 32'h0000_1000, 1'b0, 32'd0, 2'd2, mem_word(32'h0000_1000), 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h8000_0020, 1'b0, 32'd0, 2'd2, mem_word(32'h8000_0020), 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2_lsu_wins", 32'(bus_p.lsu_req_ready), 32'd1);
        checkOutput("t2_ifu_waits", 32'(bus_p.ifu_req_ready), 32'd0);
        @(posedge clk); #1 bus_p.lsu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t2_no_grant_busy", 32'(bus_p.ifu_req_ready), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("t2_ifu_grant_c4", 32'(bus_p.ifu_req_ready), 32'd1);
        @(posedge clk); #1 bus_p.ifu_req_valid = 1'b0;
        waitDrain("t2_drain");

        // Illegal half store and illegal size: error at cycle 1, memory untouched.
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h8000_0003, 1'b1, 32'hDEAD_BEEF, 2'd1, 32'd0, 1'b1, 1'b1);
        waitGrantAndDrop(1'b1);
        @(negedge clk);
        checkOutput("t3_half_rsp_c1", 32'(bus_p.lsu_rsp_valid), 32'd1);
        checkOutput("t3_half_no_mem", 32'(bus_p.mem_req_valid), 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 32'd0, 2'd3, 32'd0, 1'b1, 1'b1);
        waitGrantAndDrop(1'b1);
        @(negedge clk);
        checkOutput("t3_size3_rsp_c1", 32'(bus_p.lsu_rsp_valid), 32'd1);
        checkOutput("t3_size3_no_mem", 32'(bus_p.mem_req_valid), 32'd0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 32'h8000_0044, 1'b1, 32'hCAFE_F00D, 2'd2, 32'd0, 1'b0, 1'b1);
        waitGrantAndDrop(1'b1);
        @(negedge clk);
        checkOutput("t3_store_wen", 32'(bus_p.mem_req_wen), 32'd1);
        checkOutput("t3_store_wdata", bus_p.mem_req_wdata, 32'hCAFE_F00D);
        checkOutput("t3_store_size", 32'(bus_p.mem_req_size), 32'd2);
        waitDrain("t3_drain");

        // Silent memory: timeout error four cycles after entering WAIT, then a stray response.
        @(posedge clk); #1 bus_p.mem_rsp_valid = 1'b0;
        applyStimulus(1'b1, 32'h8000_0050, 1'b0, 32'd0, 2'd2, 32'd0, 1'b1, 1'b1);
        waitGrantAndDrop(1'b1);
        repeat (5) @(negedge clk);
        checkOutput("t4_no_rsp_c5", 32'(bus_p.lsu_rsp_valid), 32'd0);
        @(negedge clk);
        checkOutput("t4_rsp_c6", 32'(bus_p.lsu_rsp_valid), 32'd1);
        @(posedge clk); #1 bus_p.mem_rsp_valid = 1'b1;
        @(negedge clk);
        checkOutput("t4_stray_ready", 32'(bus_p.mem_rsp_ready), 32'd1);
        @(posedge clk); #1 bus_p.mem_rsp_valid = 1'b0;
        @(negedge clk);
        checkOutput("t4_stray_no_rsp", 32'({bus_p.ifu_rsp_valid, bus_p.lsu_rsp_valid}), 32'd0);
        checkOutput("t4_stray_idle", 32'(busy_p), 32'd0);
        @(posedge clk); #1 bus_p.mem_rsp_valid = 1'b1;

        // Back-pressure on both the memory request and the LSU response.
        bus_p.mem_req_ready = 1'b0;
        bus_p.lsu_rsp_ready = 1'b0;
        applyStimulus(1'b1, 32'h8000_0060, 1'b0, 32'd0, 2'd2, mem_word(32'h8000_0060), 1'b0, 1'b1);
        waitGrantAndDrop(1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_req_valid%0d", k), 32'(bus_p.mem_req_valid), 32'd1);
            checkOutput($sformatf("t5_req_addr%0d", k), bus_p.mem_req_addr, 32'h8000_0060);
        end
        @(posedge clk); #1 bus_p.mem_req_ready = 1'b1;
        applyStimulus(1'b0, 32'h0000_1100, 1'b0, 32'd0, 2'd2, mem_word(32'h0000_1100), 1'b0, 1'b1);
        found = 1'b0;
        for (int w = 0; w < 10 && !found; w++) begin
            @(negedge clk);
            found = bus_p.lsu_rsp_valid;
        end
        checkOutput("t5_rsp_seen", 32'(found), 32'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("t5_rsp_hold%0d", k), 32'(bus_p.lsu_rsp_valid), 32'd1);
            checkOutput($sformatf("t5_rdata_hold%0d", k), bus_p.lsu_rsp_rdata, mem_word(32'h8000_0060));
            checkOutput($sformatf("t5_no_grant%0d", k), 32'(bus_p.ifu_req_ready), 32'd0);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1 bus_p.lsu_rsp_ready = 1'b1;
        waitGrantAndDrop(1'b0);
        waitDrain("t5_drain");

        // Reset while waiting on memory aborts silently; the next fetch completes.
        @(posedge clk); #1 bus_p.mem_rsp_valid = 1'b0;
        applyStimulus(1'b1, 32'h8000_0070, 1'b0, 32'd0, 2'd2, 32'd0, 1'b0, 1'b0);
        waitGrantAndDrop(1'b1);
        repeat (2) @(negedge clk);
        checkOutput("t6_in_wait", 32'({busy_p, bus_p.mem_rsp_ready}), 32'd3);
        @(posedge clk); #1 rst = 1'b1;
        applyStimulus(1'b0, 32'h0000_2000, 1'b0, 32'd0, 2'd2, mem_word(32'h0000_2000), 1'b0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t6_busy", 32'(busy_p), 32'd0);
        checkOutput("t6_valids", 32'({bus_p.mem_req_valid, bus_p.lsu_rsp_valid, bus_p.ifu_rsp_valid}), 32'd0);
        checkOutput("t6_ready_in_rst", 32'(bus_p.ifu_req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_p.mem_rsp_valid = 1'b1;
        waitGrantAndDrop(1'b0);
        waitDrain("t6_drain");

        // Round-robin instance: three back-to-back ties alternate IFU, LSU, IFU.
        exp_r_ifu.push_back('{data: ~32'h0000_3000, err: 1'b0});
        exp_r_lsu.push_back('{data: ~32'h8000_0100, err: 1'b0});
        exp_r_ifu.push_back('{data: ~32'h0000_3000, err: 1'b0});
        @(posedge clk); #1;
        bus_r.ifu_req_addr  = 32'h0000_3000;
        bus_r.lsu_req_addr  = 32'h8000_0100;
        bus_r.ifu_req_valid = 1'b1;
        bus_r.lsu_req_valid = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            found = 1'b0;
            for (int w = 0; w < 12 && !found; w++) begin
                @(negedge clk);
                found = bus_r.ifu_req_ready || bus_r.lsu_req_ready;
            end
            checkOutput($sformatf("rr_found%0d", k), 32'(found), 32'd1);
            checkOutput($sformatf("rr_lsu_won%0d", k), 32'(bus_r.lsu_req_ready), 32'(k == 1));
            if (k > 0) checkOutput($sformatf("rr_spacing%0d", k), 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
        end
        @(posedge clk); #1;
        bus_r.ifu_req_valid = 1'b0;
        bus_r.lsu_req_valid = 1'b0;
        waitDrain("rr_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
